// File: rtl/mem_defs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_defs : handshake codes, op codes and state encoding for the memPc* port
// rev 1.0
// ----------------------------------------------------------------------------
package mem_defs;

   localparam logic [1:0] UMEM_OK_READY = 2'b00;
   localparam logic [1:0] UMEM_OK_OK    = 2'b01;
   localparam logic [1:0] UMEM_OK_HOLD  = 2'b10;
   localparam logic [1:0] UMEM_OK_FAULT = 2'b11;

   localparam logic [4:0] UMEM_OP_TILE  = 5'd1;
   localparam logic [4:0] UMEM_OP_DWORD = 5'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2,
      ST_FLT  = 2'd3
   } resp_state_t;

   function automatic logic op_legal(input logic [4:0] op);
      return (op == UMEM_OP_TILE) || (op == UMEM_OP_DWORD);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_lane_ram : 32-bit single-port lane RAM with registered read
// rev 1.0
// ----------------------------------------------------------------------------
module mem_lane_ram #(
   parameter int IDX_BITS = 12
) (
   input  logic                clock,
   input  logic                we,
   input  logic                re,
   input  logic [IDX_BITS-1:0] addr,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata
);

   logic [31:0] mem [0:(1<<IDX_BITS)-1];

   // Read-before-write on a shared address returns the old word.
   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule
`default_nettype wire

// File: rtl/mem_tile_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_tile_responder : SRAM-backed responder for 128-bit tile / 32-bit DWORD
// transfers on the memPc* port. rev 1.0
// ----------------------------------------------------------------------------
module mem_tile_responder
   import mem_defs::*;
#(
   parameter int          ADDR_BITS = 16,
   parameter int          LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [63:0]  memPcAddr,
   input  logic [127:0] memInData,
   input  logic         memPcOE,
   input  logic         memPcWR,
   input  logic [4:0]   memPcOp,
   output logic [127:0] memPcData,
   output logic [1:0]   memPcOK
);

   localparam int IDX_BITS = ADDR_BITS - 4;

   resp_state_t         state;
   logic [3:0]          hold_cnt;
   logic [IDX_BITS-1:0] req_idx;
   logic [1:0]          req_lane;
   logic                req_tile;
   logic                req_wr;
   logic                req_bad;
   logic [127:0]        req_data;
   logic [31:0]         lane_q [4];
   logic                in_window;
   logic                read_en;
   logic [127:0]        resp_data;
   logic                unused_addr_hi;

   assign unused_addr_hi = ^memPcAddr[63:32];
   assign in_window      = ((memPcAddr[31:0] ^ BASE_ADDR) >> ADDR_BITS) == 32'd0;
   assign read_en        = (state == ST_WAIT) && (hold_cnt == 4'd0);

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         hold_cnt <= 4'd0;
         memPcOK  <= UMEM_OK_READY;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (memPcOE || memPcWR) begin
                  req_idx  <= memPcAddr[ADDR_BITS-1:4];
                  req_lane <= memPcAddr[3:2];
                  req_tile <= (memPcOp == UMEM_OP_TILE);
                  req_wr   <= memPcWR;
                  req_bad  <= !(op_legal(memPcOp) && in_window);
                  req_data <= memInData;
                  hold_cnt <= 4'(LATENCY - 1);
                  state    <= ST_WAIT;
                  memPcOK  <= UMEM_OK_HOLD;
               end
            end
            ST_WAIT: begin
               if (hold_cnt == 4'd0) begin
                  state   <= req_bad ? ST_FLT : ST_RESP;
                  memPcOK <= req_bad ? UMEM_OK_FAULT : UMEM_OK_OK;
               end else begin
                  hold_cnt <= hold_cnt - 4'd1;
               end
            end
            ST_RESP, ST_FLT: begin
               state   <= ST_IDLE;
               memPcOK <= UMEM_OK_READY;
            end
         endcase
      end
   end

   // Writes land on the edge closing the OK cycle, after the read has been taken.
   for (genvar g = 0; g < 4; g++) begin : g_lane
      logic        lane_we;
      logic [31:0] lane_wd;
      assign lane_we = (state == ST_RESP) && req_wr && !reset &&
                       (req_tile || (req_lane == 2'(g)));
      assign lane_wd = req_tile ? req_data[32*g +: 32] : req_data[31:0];

      mem_lane_ram #(.IDX_BITS(IDX_BITS)) u_ram (
         .clock (clock),
         .we    (lane_we),
         .re    (read_en),
         .addr  (req_idx),
         .wdata (lane_wd),
         .rdata (lane_q[g])
      );
   end

   assign resp_data = req_tile ? {lane_q[3], lane_q[2], lane_q[1], lane_q[0]}
                               : {96'd0, lane_q[req_lane]};
   assign memPcData = (state == ST_RESP) ? resp_data : 128'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_tile_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_tile_responder : scoreboard bench for mem_tile_responder
// rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_tile_responder;
   import mem_defs::*;

   localparam int LAT = 2;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [63:0]  memPcAddr = '0;
   logic [127:0] memInData = '0;
   logic         memPcOE = 1'b0;
   logic         memPcWR = 1'b0;
   logic [4:0]   memPcOp = '0;
   wire  [127:0] memPcData;
   wire  [1:0]   memPcOK;

   mem_tile_responder #(.ADDR_BITS(16), .LATENCY(LAT), .BASE_ADDR(32'h0)) dut (
      .clock     (clock),
      .reset     (reset),
      .memPcAddr (memPcAddr),
      .memInData (memInData),
      .memPcOE   (memPcOE),
      .memPcWR   (memPcWR),
      .memPcOp   (memPcOp),
      .memPcData (memPcData),
      .memPcOK   (memPcOK)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [1:0]   ok;
      logic         chk;
      logic [127:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;

   always @(posedge clock) cyc++;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per OK/FAULT cycle; otherwise data must be zero.
   always @(negedge clock) begin
      exp_t e;
      if (mon_en) begin
         if (memPcOK == UMEM_OK_OK || memPcOK == UMEM_OK_FAULT) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp: got ok=%b expected no response", memPcOK);
            end else begin
               e = sb_q.pop_front();
               check("resp_ok", 128'(memPcOK), 128'(e.ok));
               if (e.chk) check("resp_data", memPcData, e.data);
            end
         end else begin
            check("nonresp_data_zero", memPcData, 128'd0);
         end
      end
   end

   task automatic req(input logic oe, input logic wr, input logic [4:0] op,
                      input logic [31:0] addr, input logic [127:0] wd,
                      input logic [1:0] eok, input logic echk, input logic [127:0] edata,
                      input bit scramble);
      int holds;
      exp_t e;
      @(negedge clock);
      check("ready_before", 128'(memPcOK), 128'(UMEM_OK_READY));
      memPcOE   = oe;
      memPcWR   = wr;
      memPcOp   = op;
      memPcAddr = {32'h0, addr};
      memInData = wd;
      e.ok = eok; e.chk = echk; e.data = edata;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      memPcOE = 1'b0;
      memPcWR = 1'b0;
      holds = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clock);
         if (memPcOK != UMEM_OK_HOLD) break;
         holds++;
         if (scramble) begin
            memPcAddr = {$urandom, $urandom};
            memInData = {$urandom, $urandom, $urandom, $urandom};
            memPcOp   = 5'($urandom);
         end
      end
      check("hold_cycles", 128'(holds), 128'(LAT));
      @(negedge clock);
      check("ready_after", 128'(memPcOK), 128'(UMEM_OK_READY));
   endtask

   localparam logic [127:0] D  = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] M  = 128'h44444444_DEADBEEF_22222222_11111111;
   localparam logic [127:0] P  = 128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C;
   localparam logic [127:0] A  = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
   localparam logic [127:0] B  = 128'hBBBB0001_BBBB0002_BBBB0003_BBBB0004;
   localparam logic [127:0] C  = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;

   initial begin
      exp_t e;
      int   k;
      int   last;
      logic [31:0] b2b_vals [4];
      b2b_vals[0] = 32'h11111111;
      b2b_vals[1] = 32'h22222222;
      b2b_vals[2] = 32'hDEADBEEF;
      b2b_vals[3] = 32'h44444444;

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_ok_during", 128'(memPcOK), 128'(UMEM_OK_READY));
      reset = 1'b0;
      @(negedge clock);
      check("reset_ok", 128'(memPcOK), 128'(UMEM_OK_READY));
      check("reset_data", memPcData, 128'd0);
      mon_en = 1'b1;

      // Tile store, then tile load ignoring addr[3:0]
      req(1'b0, 1'b1, 5'd1, 32'h120, D, UMEM_OK_OK, 1'b0, 128'd0, 1'b0);
      req(1'b1, 1'b0, 5'd1, 32'h12C, 128'd0, UMEM_OK_OK, 1'b1, D, 1'b0);

      // DWORD read-modify-write of lane 2: returns the old lane, upper store bits ignored
      req(1'b1, 1'b1, 5'd2, 32'h128, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hDEADBEEF},
          UMEM_OK_OK, 1'b1, {96'd0, 32'h33333333}, 1'b0);
      req(1'b1, 1'b0, 5'd1, 32'h120, 128'd0, UMEM_OK_OK, 1'b1, M, 1'b0);
      req(1'b1, 1'b0, 5'd2, 32'h12B, 128'd0, UMEM_OK_OK, 1'b1, {96'd0, 32'hDEADBEEF}, 1'b0);

      // Back-to-back DWORD loads with OE held high
      @(negedge clock);
      memPcOp   = 5'd2;
      memPcAddr = 64'h120;
      memPcOE   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e.ok = UMEM_OK_OK; e.chk = 1'b1; e.data = {96'd0, b2b_vals[i]};
         sb_q.push_back(e);
      end
      k = 0;
      last = 0;
      for (int n = 0; n < 40 && k < 4; n++) begin
         @(negedge clock);
         if (memPcOK == UMEM_OK_OK) begin
            if (k > 0) check("b2b_spacing", 128'(cyc - last), 128'(LAT + 2));
            last = cyc;
            k++;
            memPcAddr = 64'h120 + 64'(4 * k);
            if (k == 4) memPcOE = 1'b0;
         end
      end
      check("b2b_count", 128'(k), 128'd4);
      repeat (2) @(negedge clock);

      // Illegal op faults and leaves memory alone
      req(1'b1, 1'b1, 5'd3, 32'h120, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321,
          UMEM_OK_FAULT, 1'b1, 128'd0, 1'b0);
      req(1'b1, 1'b0, 5'd1, 32'h120, 128'd0, UMEM_OK_OK, 1'b1, M, 1'b0);

      // Out-of-window store faults and does not alias onto 0x0
      req(1'b0, 1'b1, 5'd1, 32'h0, P, UMEM_OK_OK, 1'b0, 128'd0, 1'b0);
      req(1'b0, 1'b1, 5'd1, 32'h0001_0000, ~P, UMEM_OK_FAULT, 1'b1, 128'd0, 1'b0);
      req(1'b1, 1'b0, 5'd1, 32'h0, 128'd0, UMEM_OK_OK, 1'b1, P, 1'b0);

      // Reset during WAIT aborts the store
      req(1'b0, 1'b1, 5'd1, 32'h200, A, UMEM_OK_OK, 1'b0, 128'd0, 1'b0);
      @(negedge clock);
      memPcWR   = 1'b1;
      memPcOp   = 5'd1;
      memPcAddr = 64'h200;
      memInData = B;
      @(posedge clock);
      #1;
      memPcWR = 1'b0;
      reset   = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("abort_ok", 128'(memPcOK), 128'(UMEM_OK_READY));
      check("abort_data", memPcData, 128'd0);
      req(1'b1, 1'b0, 5'd1, 32'h200, 128'd0, UMEM_OK_OK, 1'b1, A, 1'b0);

      // Inputs wiggle during WAIT; only the latched request matters
      req(1'b0, 1'b1, 5'd1, 32'h300, C, UMEM_OK_OK, 1'b0, 128'd0, 1'b1);
      req(1'b1, 1'b0, 5'd1, 32'h300, 128'd0, UMEM_OK_OK, 1'b1, C, 1'b1);
      req(1'b1, 1'b0, 5'd2, 32'h124, 128'd0, UMEM_OK_OK, 1'b1, {96'd0, 32'h22222222}, 1'b1);

      repeat (3) @(negedge clock);
      check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
